// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: decode field offsets,
// access size encodings, FSM states and the latched bus request payload.
package mem_lsu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned LD_ST_INFO_WIDTH = 5;

    // Bit offsets inside ld_st_info_i
    localparam int unsigned LSI_IS_LOAD  = 0;
    localparam int unsigned LSI_IS_STORE = 1;
    localparam int unsigned LSI_SIZE_LO  = 2;
    localparam int unsigned LSI_UNSIGNED = 4;

    localparam logic [1:0] LS_B = 2'd0;
    localparam logic [1:0] LS_H = 2'd1;
    localparam logic [1:0] LS_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic       uns;
    } ld_fmt_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Lane logic for the LSU: alignment check and store lane generation on the
// request side, load byte/halfword extraction and extension on the response side.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]      req_addr_lo,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] st_data,
    output logic            misaligned_c,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    input  logic [1:0]      rsp_addr_lo,
    input  logic [1:0]      rsp_size,
    input  logic            rsp_unsigned,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_ext_c
);

    logic [XLEN-1:0] shifted;

    // Request side: byte enables and lane-replicated store data
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'hF;
        wdata_c      = st_data;
        case (req_size)
            LS_B: begin
                be_c    = 4'b0001 << req_addr_lo;
                wdata_c = {4{st_data[7:0]}};
            end
            LS_H: begin
                misaligned_c = req_addr_lo[0];
                be_c         = 4'b0011 << {req_addr_lo[1], 1'b0};
                wdata_c      = {2{st_data[15:0]}};
            end
            default: begin
                misaligned_c = |req_addr_lo;
            end
        endcase
    end

    // Response side: move the addressed lane to bit 0, then extend
    always_comb begin
        shifted  = rdata >> {rsp_addr_lo, 3'b000};
        ld_ext_c = rdata;
        case (rsp_size)
            LS_B:    ld_ext_c = {{(XLEN-8){shifted[7] & ~rsp_unsigned}}, shifted[7:0]};
            LS_H:    ld_ext_c = {{(XLEN-16){shifted[15] & ~rsp_unsigned}}, shifted[15:0]};
            default: ld_ext_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one data-bus transaction per load/store,
// stalls the core meanwhile and reports misaligned, bus-error and timeout faults.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        lsu_req_i,
    input  logic [LD_ST_INFO_WIDTH-1:0] ld_st_info_i,
    input  logic [XLEN-1:0]             mem_addr_i,
    input  logic [XLEN-1:0]             st_data_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic [XLEN-1:0]             ld_data_o,
    output logic                        ld_valid_o,
    output logic                        misalign_o,
    output logic                        bus_err_o,
    output logic [XLEN-1:0]             fault_addr_o,
    output logic                        data_req_o,
    output logic                        data_we_o,
    output logic [XLEN-1:0]             data_addr_o,
    output logic [3:0]                  data_be_o,
    output logic [XLEN-1:0]             data_wdata_o,
    input  logic                        data_gnt_i,
    input  logic                        data_rvalid_i,
    input  logic [XLEN-1:0]             data_rdata_i,
    input  logic                        data_err_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e      state_q, state_d;
    bus_req_t        req_q, req_d;
    ld_fmt_t         fmt_q, fmt_d;
    logic            drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            data_req_q, data_req_d;
    logic            ld_valid_q, ld_valid_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;

    logic            misaligned_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] ld_ext_c;
    logic [1:0]      size_c;
    logic            timeout_c;
    logic            kill_c;

    assign size_c    = ld_st_info_i[LSI_SIZE_LO +: 2];
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign kill_c    = drop_q | flush_i;

    lsu_align u_align (
        .req_addr_lo  (mem_addr_i[1:0]),
        .req_size     (size_c),
        .st_data      (st_data_i),
        .misaligned_c (misaligned_c),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .rsp_addr_lo  (req_q.addr[1:0]),
        .rsp_size     (fmt_q.size),
        .rsp_unsigned (fmt_q.uns),
        .rdata        (data_rdata_i),
        .ld_ext_c     (ld_ext_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        fmt_d        = fmt_q;
        drop_d       = drop_q;
        data_req_d   = data_req_q;
        ld_valid_d   = 1'b0;
        ld_data_d    = ld_data_q;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        fault_addr_d = fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                drop_d     = 1'b0;
                data_req_d = 1'b0;
                if (lsu_req_i && !flush_i) begin
                    if (misaligned_c) begin
                        misalign_d   = 1'b1;
                        fault_addr_d = mem_addr_i;
                    end else begin
                        req_d.we      = ld_st_info_i[LSI_IS_STORE];
                        req_d.addr    = mem_addr_i;
                        req_d.be      = be_c;
                        req_d.wdata   = wdata_c;
                        fmt_d.is_load = ld_st_info_i[LSI_IS_LOAD];
                        fmt_d.size    = size_c;
                        fmt_d.uns     = ld_st_info_i[LSI_UNSIGNED];
                        data_req_d    = 1'b1;
                        state_d       = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A grant always wins: once accepted the response must be consumed
                if (data_gnt_i) begin
                    data_req_d = 1'b0;
                    drop_d     = flush_i;
                    state_d    = ST_RSP;
                end else if (flush_i) begin
                    data_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (timeout_c) begin
                    data_req_d   = 1'b0;
                    bus_err_d    = 1'b1;
                    fault_addr_d = req_q.addr;
                    state_d      = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (data_rvalid_i) begin
                    if (kill_c) begin
                        state_d = ST_IDLE;
                    end else if (data_err_i) begin
                        bus_err_d    = 1'b1;
                        fault_addr_d = req_q.addr;
                        state_d      = ST_IDLE;
                    end else begin
                        if (fmt_q.is_load) begin
                            ld_valid_d = 1'b1;
                            ld_data_d  = ld_ext_c;
                        end
                        state_d = ST_DONE;
                    end
                end else begin
                    drop_d = kill_c;
                    if (timeout_c) begin
                        bus_err_d    = ~kill_c;
                        fault_addr_d = kill_c ? fault_addr_q : req_q.addr;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout counter restarts on every state entry and idles at zero
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            fmt_q        <= '0;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
            data_req_q   <= 1'b0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            fmt_q        <= fmt_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            data_req_q   <= data_req_d;
            ld_valid_q   <= ld_valid_d;
            ld_data_q    <= ld_data_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Stall is combinational so the instruction holds in the same cycle it arrives
    assign stall_o      = rst_n_i & lsu_req_i & ~misaligned_c & (state_q != ST_DONE) & ~flush_i;
    assign ld_data_o    = ld_data_q;
    assign ld_valid_o   = ld_valid_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;
    assign fault_addr_o = fault_addr_q;
    assign data_req_o   = data_req_q;
    assign data_we_o    = req_q.we;
    assign data_addr_o  = {req_q.addr[XLEN-1:2], 2'b00};
    assign data_be_o    = req_q.be;
    assign data_wdata_o = req_q.wdata;

endmodule
